grid_round_controller: RTL and testbench
========================================

# grid_round_controller

Parametrised round controller for the target-selection VGA game. It generalises the fixed four-quadrant game to a COLS×ROWS grid and adds several features: a multi-round game, an on-chip pseudo-random target draw with rejection for non-power-of-two grids, a per-round countdown, scoring, and win/lose judgement. It sits between the debounced push-button pulses and the sprite, comparator and seven-segment blocks. It drives them with a target cell index, a cursor cell index, the remaining time and the game status.

## Interface
- COLS, 2, grid columns (≥1)
- ROWS, 2, grid rows (≥1); N = COLS*ROWS cells, CW = max(1,$clog2(N))
- ROUNDS, 8, rounds per game (≥1)
- WIN_SCORE, 5, hits needed to win (1..ROUNDS)
- TICKS_PER_SEC, 25_000_000, clk cycles per countdown second (≥2)
- ROUND_SECONDS, 5, seconds per round (≥1); TW = $clog2(ROUND_SECONDS+1)
- SEED, 16'hACE1, LFSR reset value (nonzero)
- clk  in  1  system clock (25 MHz pixel clock domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, debounced; begins a game
- select  in  1  one-cycle pulse, debounced; commits cursor as guess
- move  in  1  one-cycle pulse, debounced; advances cursor
- state  out  3  IDLE=0, DRAW=1, PLAY=2, DONE=3
- cursor  out  CW  player's cell index, 0..N-1
- target  out  CW  drawn cell index, 0..N-1
- target_valid  out  1  high only in PLAY
- time_left  out  TW  whole seconds remaining in the round
- round  out  $clog2(ROUNDS+1)  rounds completed this game
- score  out  $clog2(ROUNDS+1)  hits this game
- hit  out  1  one-cycle pulse, correct guess
- miss  out  1  one-cycle pulse, wrong guess or timeout
- game_over  out  1  high in DONE
- win  out  1  high in DONE when score ≥ WIN_SCORE

## Operation
- Reset: all outputs 0; state IDLE; LFSR = SEED; prescaler = 0.
- LFSR: 16-bit Galois, mask 16'hB400. It shifts every cycle in every state, including during reset release, and is never reloaded except by rst.
- IDLE: start → DRAW. On the same edge, clear score, round, cursor and time_left. Ignore select and move.
- DRAW: candidate = LFSR[CW-1:0].
  - If candidate < N: load target, set time_left = ROUND_SECONDS, prescaler = 0, go to PLAY.
  - Otherwise stay in DRAW and retry next cycle.
  - Target is updated only in DRAW. It holds its value in all other states.
- PLAY: the prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements.
  - select: if cursor == target, pulse hit and increment score. Otherwise pulse miss.
  - Timeout: the wrap that takes time_left from 1 to 0 pulses miss.
  - Both events end the round: increment round. If the new round == ROUNDS, go to DONE; otherwise go to DRAW.
  - move: cursor = (cursor == N-1) ? 0 : cursor+1.
- DONE: game_over=1, and win = (score ≥ WIN_SCORE). Score and round are held. start → DRAW, with the same clearing as in IDLE.
- start in DRAW or PLAY is ignored. move outside PLAY is ignored.
- Simultaneous events:
  - select and timeout in the same cycle: select is judged and only one pulse fires.
  - select and move in the same cycle: judge the pre-move cursor, and the cursor still advances.
  - N=1: cursor stays 0 and every DRAW accepts immediately.
- Reset mid-game: return immediately to the reset values. No pulse is emitted.

## Timing
- All outputs are registered. hit and miss assert in the cycle after the select edge, or after the timeout wrap edge. score, round and state update on that same edge.
- start at edge t: state = DRAW after t, and PLAY after t+1 at the earliest (target_valid high from then on).
- Each DRAW rejection adds exactly 1 cycle.
- A PLAY with no select lasts exactly ROUND_SECONDS*TICKS_PER_SEC cycles.
- A select is honoured on any PLAY cycle, including the first and the timeout cycle.
- hit and miss are never high together, and each is never high for 2 consecutive cycles.

## Test plan
Bench parameters: COLS=3, ROWS=2, ROUNDS=3, WIN_SCORE=2, TICKS_PER_SEC=4, ROUND_SECONDS=3.
- Reset then 10 idle cycles → state=0, all outputs 0, and a reference LFSR model tracks SEED from the release edge.
- start → DRAW next cycle. Every LFSR candidate ≥6 holds DRAW one more cycle (checked against the model). When a candidate is accepted, target = candidate, time_left=3, target_valid=1.
- In PLAY, move until cursor==target, then select → one hit pulse, score=1, round=1, state=DRAW. Then 6 more moves from cursor=5 → cursor wraps 0→…→5.
- No select for 12 cycles → time_left 3→2→1 at cycles 4 and 8, miss at cycle 12, round advances.
- select coinciding with the timeout cycle and cursor==target → hit only, score increments. Separately, select+move with cursor=target-1 → miss and cursor=target.
- Play 2 hits + 1 miss → DONE with score=2, win=1, game_over=1. start restarts with score=0 and round=0. Assert rst mid-PLAY → all outputs 0 on the next sample, with no hit or miss pulse.

Source files
------------

// File: rtl/grid_round_controller.sv
// grid_round_controller
// Multi-round target-selection game controller for a COLS x ROWS grid.
// Draws a pseudo-random target (rejecting out-of-range LFSR candidates), runs
// a per-round seconds countdown, judges the player's guess, keeps score and
// reports the final win/lose status.  Every output comes straight from a flop.
module grid_round_controller #(
  parameter int          COLS          = 2,
  parameter int          ROWS          = 2,
  parameter int          ROUNDS        = 8,
  parameter int          WIN_SCORE     = 5,
  parameter int          TICKS_PER_SEC = 25_000_000,
  parameter int          ROUND_SECONDS = 5,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         N             = COLS * ROWS,
  localparam int         CW            = (N > 1) ? $clog2(N) : 1,
  localparam int         TW            = $clog2(ROUND_SECONDS + 1),
  localparam int         RW            = $clog2(ROUNDS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,          // asynchronous, active-low
  input  logic          i_start,
  input  logic          i_select,
  input  logic          i_move,
  output logic [2:0]    o_state,
  output logic [CW-1:0] o_cursor,
  output logic [CW-1:0] o_target,
  output logic          o_target_valid,
  output logic [TW-1:0] o_time_left,
  output logic [RW-1:0] o_round,
  output logic [RW-1:0] o_score,
  output logic          o_hit,
  output logic          o_miss,
  output logic          o_game_over,
  output logic          o_win
);

  localparam int PW = $clog2(TICKS_PER_SEC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRAW = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;

  localparam logic [PW-1:0] PRE_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW:0]   N_EXT     = (CW + 1)'(N);
  localparam logic [CW-1:0] LAST_CELL = CW'(N - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(ROUND_SECONDS);
  localparam logic [RW-1:0] R_LAST    = RW'(ROUNDS);
  localparam logic [RW-1:0] S_WIN     = RW'(WIN_SCORE);
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cursor;
  logic [CW-1:0] r_target;
  logic [TW-1:0] r_time;
  logic [RW-1:0] r_round;
  logic [RW-1:0] r_score;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_lfsr;
  logic          r_hit;
  logic          r_miss;
  logic          r_tv;
  logic          r_go;
  logic          r_win;

  logic [2:0]    w_state_n;
  logic [CW-1:0] w_cursor_n;
  logic [CW-1:0] w_target_n;
  logic [TW-1:0] w_time_n;
  logic [RW-1:0] w_round_n;
  logic [RW-1:0] w_score_n;
  logic [PW-1:0] w_presc_n;
  logic          w_hit_n;
  logic          w_miss_n;

  logic [CW-1:0] w_cand;
  logic          w_accept;
  logic [CW-1:0] w_cand_tgt;
  logic          w_tick;
  logic          w_timeout;
  logic [RW-1:0] w_round_inc;

  // A single-cell grid has only cell 0, so any candidate is accepted as 0.
  assign w_cand      = r_lfsr[CW-1:0];
  assign w_accept    = (N == 1) || ({1'b0, w_cand} < N_EXT);
  assign w_cand_tgt  = (N == 1) ? '0 : w_cand;
  assign w_tick      = (r_presc == PRE_MAX);
  assign w_timeout   = w_tick && (r_time == TW'(1));
  assign w_round_inc = r_round + RW'(1);

  // Next-state and next-output decision for the game sequencer.
  always_comb begin
    w_state_n  = r_state;
    w_cursor_n = r_cursor;
    w_target_n = r_target;
    w_time_n   = r_time;
    w_round_n  = r_round;
    w_score_n  = r_score;
    w_presc_n  = r_presc;
    w_hit_n    = 1'b0;
    w_miss_n   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_n  = S_DRAW;
          w_score_n  = '0;
          w_round_n  = '0;
          w_cursor_n = '0;
          w_time_n   = '0;
        end
      end
      S_DRAW: begin
        // Out-of-range candidates are simply retried on the next LFSR value.
        if (w_accept) begin
          w_target_n = w_cand_tgt;
          w_time_n   = T_FULL;
          w_presc_n  = '0;
          w_state_n  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          w_presc_n = '0;
          w_time_n  = r_time - TW'(1);
        end else begin
          w_presc_n = r_presc + PW'(1);
        end
        // A select always wins over a coincident timeout: one judgement only.
        if (i_select || w_timeout) begin
          if (i_select && (r_cursor == r_target)) begin
            w_hit_n   = 1'b1;
            w_score_n = r_score + RW'(1);
          end else begin
            w_miss_n  = 1'b1;
          end
          w_round_n = w_round_inc;
          w_state_n = (w_round_inc == R_LAST) ? S_DONE : S_DRAW;
        end
        // The guess above was judged on the pre-move cursor.
        if (i_move) begin
          w_cursor_n = (r_cursor == LAST_CELL) ? '0 : r_cursor + CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Game state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_cursor <= '0;
      r_target <= '0;
      r_time   <= '0;
      r_round  <= '0;
      r_score  <= '0;
      r_presc  <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_tv     <= 1'b0;
      r_go     <= 1'b0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cursor <= w_cursor_n;
      r_target <= w_target_n;
      r_time   <= w_time_n;
      r_round  <= w_round_n;
      r_score  <= w_score_n;
      r_presc  <= w_presc_n;
      r_hit    <= w_hit_n;
      r_miss   <= w_miss_n;
      r_tv     <= (w_state_n == S_PLAY);
      r_go     <= (w_state_n == S_DONE);
      r_win    <= (w_state_n == S_DONE) && (w_score_n >= S_WIN);
    end
  end

  // Free-running 16-bit Galois LFSR; only reset reloads the seed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign o_state        = r_state;
  assign o_cursor       = r_cursor;
  assign o_target       = r_target;
  assign o_target_valid = r_tv;
  assign o_time_left    = r_time;
  assign o_round        = r_round;
  assign o_score        = r_score;
  assign o_hit          = r_hit;
  assign o_miss         = r_miss;
  assign o_game_over    = r_go;
  assign o_win          = r_win;

endmodule

// File: tb/tb_grid_round_controller.sv
// Testbench for grid_round_controller: directed game scenarios plus a random
// phase, all checked against a rule-level reference model of the game.
module tb_grid_round_controller;

  localparam int COLS = 3;
  localparam int ROWS = 2;
  localparam int ROUNDS = 3;
  localparam int WIN_SCORE = 2;
  localparam int TPS = 4;
  localparam int RSEC = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int N = COLS * ROWS;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_select;
  logic       i_move;
  logic [2:0] o_state;
  logic [2:0] o_cursor;
  logic [2:0] o_target;
  logic       o_target_valid;
  logic [1:0] o_time_left;
  logic [1:0] o_round;
  logic [1:0] o_score;
  logic       o_hit;
  logic       o_miss;
  logic       o_game_over;
  logic       o_win;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state (plain integers, game rules only)
  int          m_state, m_cursor, m_target, m_time, m_round, m_score, m_presc;
  bit          m_hit, m_miss;
  logic [15:0] m_lfsr;

  grid_round_controller #(
    .COLS(COLS), .ROWS(ROWS), .ROUNDS(ROUNDS), .WIN_SCORE(WIN_SCORE),
    .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RSEC), .SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_select(i_select),
    .i_move(i_move), .o_state(o_state), .o_cursor(o_cursor),
    .o_target(o_target), .o_target_valid(o_target_valid),
    .o_time_left(o_time_left), .o_round(o_round), .o_score(o_score),
    .o_hit(o_hit), .o_miss(o_miss), .o_game_over(o_game_over), .o_win(o_win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cursor = 0; m_target = 0; m_time = 0;
    m_round = 0; m_score = 0; m_presc = 0;
    m_hit = 0; m_miss = 0;
    m_lfsr = SEED;
  endtask

  // One clock edge of the game, straight from the rules.
  task automatic model_edge(input bit s, input bit sel, input bit mv);
    int cand;
    bit sec_end, tout, ended;
    m_hit = 0;
    m_miss = 0;
    case (m_state)
      0, 3: if (s) begin
        m_state = 1; m_score = 0; m_round = 0; m_cursor = 0; m_time = 0;
      end
      1: begin
        cand = int'(m_lfsr % 8);
        if (cand < N) begin
          m_target = cand; m_time = RSEC; m_presc = 0; m_state = 2;
        end
      end
      2: begin
        sec_end = (m_presc == TPS - 1);
        m_presc = (m_presc + 1) % TPS;
        if (sec_end) m_time = m_time - 1;
        tout = sec_end && (m_time == 0);
        ended = 0;
        if (sel) begin
          ended = 1;
          if (m_cursor == m_target) begin m_hit = 1; m_score++; end
          else m_miss = 1;
        end else if (tout) begin
          ended = 1; m_miss = 1;
        end
        if (ended) begin
          m_round++;
          m_state = (m_round == ROUNDS) ? 3 : 1;
        end
        if (mv) m_cursor = (m_cursor + 1) % N;
      end
      default: ;
    endcase
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},     32'(o_state),        32'(m_state));
    chk({tag, ".cursor"},    32'(o_cursor),       32'(m_cursor));
    chk({tag, ".target"},    32'(o_target),       32'(m_target));
    chk({tag, ".tvalid"},    32'(o_target_valid), 32'(m_state == 2));
    chk({tag, ".time_left"}, 32'(o_time_left),    32'(m_time));
    chk({tag, ".round"},     32'(o_round),        32'(m_round));
    chk({tag, ".score"},     32'(o_score),        32'(m_score));
    chk({tag, ".hit"},       32'(o_hit),          32'(m_hit));
    chk({tag, ".miss"},      32'(o_miss),         32'(m_miss));
    chk({tag, ".game_over"}, 32'(o_game_over),    32'(m_state == 3));
    chk({tag, ".win"},       32'(o_win),          32'(m_state == 3 && m_score >= WIN_SCORE));
  endtask

  // Called at posedge+1: drive, take the edge, then sample at posedge+1.
  task automatic step(input bit s, input bit sel, input bit mv);
    i_start = s; i_select = sel; i_move = mv;
    @(posedge clk);
    model_edge(s, sel, mv);
    #1;
    check_all("step");
    i_start = 0; i_select = 0; i_move = 0;
  endtask

  task automatic wait_play();
    int k = 0;
    while (m_state == 1 && k < 64) begin
      step(0, 0, 0);
      k++;
    end
    chk("reach_play", 32'(o_target_valid), 32'd1);
  endtask

  task automatic move_to(input int dest);
    int g = 0;
    while (m_cursor != dest && g < 8) begin
      step(0, 0, 1);
      g++;
    end
    chk("move_to", 32'(o_cursor), 32'(dest));
  endtask

  initial begin
    int k;
    i_rst = 0; i_start = 0; i_select = 0; i_move = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    i_rst = 1;

    // idle: select/move ignored, LFSR keeps running
    for (int i = 0; i < 10; i++) step(0, 1'($urandom % 2), 1'($urandom % 2));
    chk("idle_state", 32'(o_state), 32'd0);

    // start, draw with rejections, first play
    step(1, 0, 0);
    chk("start_draw", 32'(o_state), 32'd1);
    wait_play();
    chk("play_time_full", 32'(o_time_left), 32'(RSEC));

    // round 1: hit
    move_to(m_target);
    step(0, 1, 0);
    chk("r1_hit", 32'(o_hit), 32'd1);
    chk("r1_score", 32'(o_score), 32'd1);
    chk("r1_round", 32'(o_round), 32'd1);
    chk("r1_state", 32'(o_state), 32'd1);

    // round 2: cursor wrap, then timeout after exactly 12 PLAY cycles
    wait_play();
    k = 0;
    while (m_cursor != 5 && k < 8) begin step(0, 0, 1); k++; end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      k++;
      chk("wrap_cursor", 32'(o_cursor), 32'(i % N));
    end
    while (o_state == 3'd2 && k < 40) begin step(0, 0, 0); k++; end
    chk("timeout_len", 32'(k), 32'(RSEC * TPS));
    chk("timeout_miss", 32'(o_miss), 32'd1);
    chk("timeout_round", 32'(o_round), 32'd2);

    // round 3: select on the timeout cycle with the right cursor
    wait_play();
    for (int i = 1; i < RSEC * TPS; i++) step(0, 0, 1'(m_cursor != m_target));
    step(0, 1, 0);
    chk("tsel_hit", 32'(o_hit), 32'd1);
    chk("tsel_nomiss", 32'(o_miss), 32'd0);
    chk("done_state", 32'(o_state), 32'd3);
    chk("done_score", 32'(o_score), 32'd2);
    chk("done_win", 32'(o_win), 32'd1);
    chk("done_over", 32'(o_game_over), 32'd1);

    // done: inputs other than start ignored; restart clears
    for (int i = 0; i < 3; i++) step(0, 1'($urandom % 2), 1'($urandom % 2));
    step(1, 0, 0);
    chk("restart_score", 32'(o_score), 32'd0);
    chk("restart_round", 32'(o_round), 32'd0);

    // select + move with cursor one behind target
    wait_play();
    move_to((m_target + N - 1) % N);
    step(0, 1, 1);
    chk("selmv_miss", 32'(o_miss), 32'd1);
    chk("selmv_nohit", 32'(o_hit), 32'd0);
    chk("selmv_cursor", 32'(o_cursor), 32'(m_target));

    // random phase
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(15) == 0), 1'($urandom_range(15) == 0),
           1'($urandom_range(3) == 0));

    // asynchronous reset in the middle of PLAY
    if (m_state == 0 || m_state == 3) step(1, 0, 0);
    wait_play();
    step(0, 0, 1);
    i_select = 1;
    #2;
    i_rst = 0;
    #1;
    model_reset();
    check_all("rst_async");
    i_select = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    i_rst = 1;

    // after reset the LFSR restarts from the seed
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(1, 0, 0);
    wait_play();
    for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(7) == 0), 1'($urandom % 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
